// File: rtl/bht_update_ctrl.sv
// Branch history table sequencer: post-reset/flush clear sweep, lookup-first port
// arbitration, and queued 2-bit saturating-counter read-modify-write updates.
module bht_update_ctrl #(
    parameter int WIDTH_PC   = 32,
    parameter int IDX_W      = 7,
    parameter int TAG_W      = 7,
    parameter int FIFO_DEPTH = 4,
    localparam int ENTRY_W   = 3 + TAG_W + WIDTH_PC - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                lk_req,
    input  logic [WIDTH_PC-1:0] lk_pc,
    output logic                lk_gnt,
    output logic                lk_rvalid,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [WIDTH_PC-1:0] upd_pc,
    input  logic [WIDTH_PC-1:0] upd_target,
    input  logic                upd_taken,
    output logic                init_busy,
    output logic                tbl_en,
    output logic                tbl_we,
    output logic [IDX_W-1:0]    tbl_addr,
    output logic [ENTRY_W-1:0]  tbl_wdata,
    input  logic [ENTRY_W-1:0]  tbl_rdata
);
    localparam int TGT_W = WIDTH_PC - 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             lk_rvalid_q;

    logic [IDX_W-1:0] fifo_idx_q   [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q   [FIFO_DEPTH];
    logic [TGT_W-1:0] fifo_tgt_q   [FIFO_DEPTH];
    logic             fifo_taken_q [FIFO_DEPTH];

    logic             push, pop, full, en_c, we_c;
    logic [IDX_W-1:0] lk_idx, upd_idx, head_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             unused_pc_bits;

    // Status encoding: 00 JUMP, 01 WEAK_JUMP, 11 WEAK_NORM, 10 NORM.
    function automatic logic [1:0] step_status(input logic [1:0] st, input logic taken);
        logic [1:0] nx;
        if (taken) begin
            case (st)
                2'b10:   nx = 2'b11;
                2'b11:   nx = 2'b01;
                default: nx = 2'b00;
            endcase
        end else begin
            case (st)
                2'b00:   nx = 2'b01;
                2'b01:   nx = 2'b11;
                default: nx = 2'b10;
            endcase
        end
        return nx;
    endfunction

    function automatic logic [ENTRY_W-1:0] merge_entry(input logic [ENTRY_W-1:0] rd,
                                                       input logic [TAG_W-1:0]   tag,
                                                       input logic [TGT_W-1:0]   tgt,
                                                       input logic               taken);
        logic [1:0]       st;
        logic [TGT_W-1:0] t;
        if (rd[ENTRY_W-1] && (rd[TGT_W +: TAG_W] == tag)) begin
            st = step_status(rd[TGT_W+TAG_W +: 2], taken);
            t  = taken ? tgt : rd[TGT_W-1:0];
        end else begin
            st = taken ? 2'b01 : 2'b11;
            t  = tgt;
        end
        return {1'b1, st, tag, t};
    endfunction

    assign lk_idx   = lk_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign push     = upd_valid && !full && !flush;

    assign upd_ready = !full;
    assign init_busy = (state_q == S_INIT);
    assign lk_rvalid = lk_rvalid_q;
    // The sweep state is entered during reset; keep the port quiet until release.
    assign tbl_en    = en_c && rst_n;
    assign tbl_we    = we_c && rst_n;

    assign unused_pc_bits = ^{lk_pc[1:0], lk_pc[WIDTH_PC-1:IDX_W+2], upd_pc[1:0],
                              upd_pc[WIDTH_PC-1:IDX_W+TAG_W+2], upd_target[1:0]};

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pop       = 1'b0;
        lk_gnt    = 1'b0;
        en_c      = 1'b0;
        we_c      = 1'b0;
        tbl_addr  = sweep_q;
        tbl_wdata = '0;
        case (state_q)
            S_INIT: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (lk_req) begin
                    lk_gnt   = 1'b1;
                    en_c     = 1'b1;
                    tbl_addr = lk_idx;
                end else if (count_q != '0) begin
                    en_c     = 1'b1;
                    tbl_addr = head_idx;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                en_c      = 1'b1;
                we_c      = 1'b1;
                tbl_addr  = head_idx;
                tbl_wdata = merge_entry(tbl_rdata, fifo_tag_q[rd_ptr_q],
                                        fifo_tgt_q[rd_ptr_q], fifo_taken_q[rd_ptr_q]);
                pop       = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        // Flush wins over everything; a WRITE in this cycle has already been issued.
        if (flush) begin
            state_d  = S_INIT;
            sweep_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lk_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lk_rvalid_q <= lk_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]   <= upd_idx;
            fifo_tag_q[wr_ptr_q]   <= upd_tag;
            fifo_tgt_q[wr_ptr_q]   <= upd_target[WIDTH_PC-1:2];
            fifo_taken_q[wr_ptr_q] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Randomized bench for bht_update_ctrl against a transaction-level model of the
// table, the update queue and the sweep, with a behavioural single-port table.
module tb_bht_update_ctrl;
    localparam int N     = 128;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        lk_req;
    logic [31:0] lk_pc;
    logic        lk_gnt;
    logic        lk_rvalid;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        init_busy;
    logic        tbl_en;
    logic        tbl_we;
    logic [6:0]  tbl_addr;
    logic [39:0] tbl_wdata;
    logic [39:0] tbl_rdata;

    always #5 clk = ~clk;

    bht_update_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .lk_req     (lk_req),
        .lk_pc      (lk_pc),
        .lk_gnt     (lk_gnt),
        .lk_rvalid  (lk_rvalid),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .init_busy  (init_busy),
        .tbl_en     (tbl_en),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .tbl_rdata  (tbl_rdata)
    );

    // Single-port table; filled with garbage while in reset so the sweep matters.
    logic [39:0] mem [N];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= 40'({$urandom, $urandom});
        end else if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            tbl_rdata <= mem[tbl_addr];
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          taken;
    } upd_t;

    upd_t        q[$];
    bit          m_valid [N];
    int          m_str   [N];   // 0 NORM .. 3 JUMP
    logic [6:0]  m_tag   [N];
    logic [29:0] m_tgt   [N];
    int          sweep_left;
    bit          writing;
    bit          exp_rvalid;
    logic [39:0] exp_rdata;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] m_entry(input int i);
        logic [1:0] enc;
        case (m_str[i])
            3:       enc = 2'b00;
            2:       enc = 2'b01;
            1:       enc = 2'b11;
            default: enc = 2'b10;
        endcase
        return {m_valid[i], enc, m_tag[i], m_tgt[i]};
    endfunction

    task automatic m_clear(input int i);
        m_valid[i] = 1'b0;
        m_str[i]   = 3;
        m_tag[i]   = '0;
        m_tgt[i]   = '0;
    endtask

    task automatic m_apply(input upd_t u);
        int         i;
        logic [6:0] t;
        i = int'(u.pc[8:2]);
        t = u.pc[15:9];
        if (m_valid[i] && m_tag[i] == t) begin
            if (u.taken) begin
                m_str[i] = (m_str[i] < 3) ? m_str[i] + 1 : 3;
                m_tgt[i] = u.tgt[31:2];
            end else begin
                m_str[i] = (m_str[i] > 0) ? m_str[i] - 1 : 0;
            end
        end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_tgt[i]   = u.tgt[31:2];
            m_str[i]   = u.taken ? 2 : 1;
        end
    endtask

    // Starts at a negedge: drive, check, advance the model, wait for the next negedge.
    task automatic cyc(input bit lq, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input logic [31:0] utgt,
                       input bit ut, input bit fl);
        bit   idle_now, gnt, can_push;
        upd_t u;
        lk_req     = lq;
        lk_pc      = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_target = utgt;
        upd_taken  = ut;
        flush      = fl;
        #1;
        idle_now = (sweep_left == 0) && !writing;
        gnt      = idle_now && lq;
        chk("init_busy", 64'(init_busy), 64'(sweep_left > 0));
        chk("lk_gnt", 64'(lk_gnt), 64'(gnt));
        chk("upd_ready", 64'(upd_ready), 64'(q.size() < DEPTH));
        chk("lk_rvalid", 64'(lk_rvalid), 64'(exp_rvalid));
        if (exp_rvalid) chk("lk_rdata", 64'(tbl_rdata), 64'(exp_rdata));

        exp_rvalid = gnt;
        if (gnt) exp_rdata = m_entry(int'(lpc[8:2]));
        can_push = uv && (q.size() < DEPTH) && !fl;
        if (sweep_left > 0) begin
            m_clear(N - sweep_left);
            sweep_left--;
        end else if (writing) begin
            m_apply(q[0]);
            void'(q.pop_front());
            writing = 1'b0;
        end else if (!lq && q.size() > 0) begin
            writing = 1'b1;
        end
        if (can_push) begin
            u.pc    = upc;
            u.tgt   = utgt;
            u.taken = ut;
            q.push_back(u);
        end
        if (fl) begin
            q.delete();
            sweep_left = N;
            writing    = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
        cyc(1'b0, '0, 1'b1, pc, tgt, tk, 1'b0);
        idle(3);
    endtask

    task automatic cmp_all();
        for (int i = 0; i < N; i++) chk("tbl_entry", 64'(mem[i]), 64'(m_entry(i)));
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p       = $urandom;
        p[8:2]  = 7'($urandom_range(0, 7));
        p[15:9] = 7'($urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; lk_req = 1'b1; lk_pc = 32'h204;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        for (int i = 0; i < N; i++) m_clear(i);
        q.delete();
        sweep_left = N; writing = 1'b0; exp_rvalid = 1'b0; exp_rdata = '0;

        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_tbl_en", 64'(tbl_en), 64'(0));
            chk("rst_init_busy", 64'(init_busy), 64'(1));
            chk("rst_lk_gnt", 64'(lk_gnt), 64'(0));
            chk("rst_upd_ready", 64'(upd_ready), 64'(1));
            chk("rst_lk_rvalid", 64'(lk_rvalid), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep with lookups requested throughout.
        for (int i = 0; i < N; i++) cyc(1'b1, rpc(), 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
        chk("sweep_mem0", 64'(mem[0]), 64'(0));
        chk("sweep_mem127", 64'(mem[127]), 64'(0));

        // Counter walk on index 1.
        upd(32'h0000_0204, 32'h0000_0400, 1'b1);
        chk("alloc_taken", 64'(mem[1]), 64'({1'b1, 2'b01, 7'h01, 30'h100}));
        upd(32'h0000_0204, 32'h0000_0400, 1'b1);
        chk("taken_to_jump", 64'(mem[1]), 64'({1'b1, 2'b00, 7'h01, 30'h100}));
        upd(32'h0000_0204, 32'h0000_0400, 1'b1);
        chk("taken_saturate", 64'(mem[1]), 64'({1'b1, 2'b00, 7'h01, 30'h100}));
        upd(32'h0000_0204, 32'h0000_0999, 1'b0);
        chk("nt_weak_jump", 64'(mem[1]), 64'({1'b1, 2'b01, 7'h01, 30'h100}));
        upd(32'h0000_0204, 32'h0000_0999, 1'b0);
        chk("nt_weak_norm", 64'(mem[1]), 64'({1'b1, 2'b11, 7'h01, 30'h100}));
        upd(32'h0000_0204, 32'h0000_0999, 1'b0);
        chk("nt_norm", 64'(mem[1]), 64'({1'b1, 2'b10, 7'h01, 30'h100}));
        upd(32'h0000_0204, 32'h0000_0999, 1'b0);
        chk("nt_saturate", 64'(mem[1]), 64'({1'b1, 2'b10, 7'h01, 30'h100}));
        cyc(1'b1, 32'h0000_0204, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);

        // Lookups hold the port while the queue fills.
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'h0000_0204, 1'b1, 32'h14 + 32'(4 * i), 32'h1000 + 32'(i), i[0], 1'b0);
        chk("full_ready", 64'(upd_ready), 64'(0));
        idle(12);
        cmp_all();

        // Tag conflict reallocates index 1.
        upd(32'h0000_0404, 32'h0000_0800, 1'b1);
        chk("tag_realloc", 64'(mem[1]), 64'({1'b1, 2'b01, 7'h02, 30'h200}));

        // Flush with three queued updates.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h0, 1'b1, 32'h50 + 32'(4 * i), 32'h2000, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 32'h60, 32'h3000, 1'b1, 1'b1);
        idle(132);
        chk("flush_drop", 64'(mem[20]), 64'(0));
        cmp_all();

        for (int s = 0; s < 6; s++) begin
            int p_lk, p_up;
            p_lk = (s % 3) * 30 + 10;
            p_up = 30 + s * 10;
            for (int c = 0; c < 400; c++)
                cyc($urandom_range(0, 99) < p_lk, rpc(), $urandom_range(0, 99) < p_up,
                    rpc(), $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 400; i++)
            if (sweep_left > 0 || writing || q.size() > 0) idle(1);
        cmp_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
